// File: rtl/muller_hs_pkg.sv
// Shared definitions for the Muller C-element handshake driver:
// FSM state encoding and default parameter values.
package muller_hs_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_R_LEAD = 3'd1,
    S_R_SKEW = 3'd2,
    S_W_HI   = 3'd3,
    S_F_LEAD = 3'd4,
    S_F_SKEW = 3'd5,
    S_W_LO   = 3'd6,
    S_ERR    = 3'd7
  } hs_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TMO_W       = 8;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/muller_c_handshake_driver_if.sv
// Control, stimulus and status signals of the C-element handshake driver.
// master: the driver itself; slave: whoever controls and observes it.
interface muller_c_handshake_driver_if #(
  parameter int TMO_W = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             clr;
  logic             lead_b;
  logic [3:0]       skew;
  logic [TMO_W-1:0] tmo_lim;
  logic             c_in;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic [CNT_W-1:0] done_cnt;
  logic             err_tmo;
  logic             err_glitch;

  modport master (
    input  start, stop, clr, lead_b, skew, tmo_lim, c_in,
    output a_out, b_out, busy, done_cnt, err_tmo, err_glitch
  );

  modport slave (
    output start, stop, clr, lead_b, skew, tmo_lim, c_in,
    input  a_out, b_out, busy, done_cnt, err_tmo, err_glitch
  );
endinterface

// File: rtl/muller_sync.sv
// Flop-chain synchronizer for the asynchronous C-element output.
module muller_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [STAGES-1:0] ff_q;

  // Shift the async input through STAGES flops; cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/muller_c_handshake_driver.sv
// Four-phase stimulus driver for a Muller C-element: drives A/B through
// rise/fall handshakes with programmable skew, waits for the synchronized
// C output, counts completed handshakes and flags timeouts/glitches.
module muller_c_handshake_driver
  import muller_hs_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TMO_W       = DEF_TMO_W,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  muller_c_handshake_driver_if.master bus
);
  hs_state_e        state_q, state_d;
  logic             a_q, a_d, b_q, b_d;
  logic [3:0]       skew_cnt_q, skew_cnt_d;
  logic [TMO_W-1:0] tmo_lim_q, tmo_lim_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] done_q, done_d;
  logic             err_tmo_q, err_tmo_d;
  logic             err_glitch_q, err_glitch_d;
  logic             c_s;
  logic             go_lead;
  logic             lead_lvl;

  // A zero limit disables the timeout; otherwise fire when the count would reach it.
  function automatic logic tmo_hit(input logic [TMO_W-1:0] cnt,
                                   input logic [TMO_W-1:0] lim);
    return (lim != '0) && ((cnt + TMO_W'(1)) == lim);
  endfunction

  muller_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.c_in),
    .q_o   (c_s)
  );

  // State and datapath registers; reset drops A/B immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      skew_cnt_q   <= '0;
      tmo_lim_q    <= '0;
      tmo_q        <= '0;
      done_q       <= '0;
      err_tmo_q    <= 1'b0;
      err_glitch_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      skew_cnt_q   <= skew_cnt_d;
      tmo_lim_q    <= tmo_lim_d;
      tmo_q        <= tmo_d;
      done_q       <= done_d;
      err_tmo_q    <= err_tmo_d;
      err_glitch_q <= err_glitch_d;
    end
  end

  // Next-state logic. The lead edge is launched on the transition into
  // R_LEAD/F_LEAD so it appears one cycle after the request; skew, lead
  // selection and timeout limit are captured on that same edge.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    skew_cnt_d   = skew_cnt_q;
    tmo_lim_d    = tmo_lim_q;
    tmo_d        = tmo_q;
    done_d       = done_q;
    err_tmo_d    = err_tmo_q;
    err_glitch_d = err_glitch_q;
    go_lead      = 1'b0;
    lead_lvl     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && c_s) begin
          state_d      = S_ERR;
          err_glitch_d = 1'b1;
        end else if (bus.start && !bus.stop) begin
          go_lead  = 1'b1;
          lead_lvl = 1'b1;
        end
      end
      S_R_LEAD, S_R_SKEW: begin
        if (c_s) begin
          state_d      = S_ERR;
          err_glitch_d = 1'b1;
        end else if (skew_cnt_q <= 4'd1) begin
          a_d     = 1'b1;
          b_d     = 1'b1;
          tmo_d   = '0;
          state_d = S_W_HI;
        end else begin
          skew_cnt_d = skew_cnt_q - 4'd1;
          state_d    = S_R_SKEW;
        end
      end
      S_W_HI: begin
        if (c_s) begin
          go_lead  = 1'b1;
          lead_lvl = 1'b0;
        end else if (tmo_hit(tmo_q, tmo_lim_q)) begin
          state_d   = S_ERR;
          err_tmo_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_F_LEAD, S_F_SKEW: begin
        if (!c_s) begin
          state_d      = S_ERR;
          err_glitch_d = 1'b1;
        end else if (skew_cnt_q <= 4'd1) begin
          a_d     = 1'b0;
          b_d     = 1'b0;
          tmo_d   = '0;
          state_d = S_W_LO;
        end else begin
          skew_cnt_d = skew_cnt_q - 4'd1;
          state_d    = S_F_SKEW;
        end
      end
      S_W_LO: begin
        if (!c_s) begin
          done_d = done_q + CNT_W'(1);
          if (bus.stop || !bus.start) begin
            state_d = S_IDLE;
          end else begin
            go_lead  = 1'b1;
            lead_lvl = 1'b1;
          end
        end else if (tmo_hit(tmo_q, tmo_lim_q)) begin
          state_d   = S_ERR;
          err_tmo_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (go_lead) begin
      state_d    = lead_lvl ? S_R_LEAD : S_F_LEAD;
      skew_cnt_d = bus.skew;
      tmo_lim_d  = bus.tmo_lim;
      if (bus.lead_b) b_d = lead_lvl;
      else            a_d = lead_lvl;
      if (bus.skew == 4'd0) begin
        a_d = lead_lvl;
        b_d = lead_lvl;
      end
    end

    if (state_d == S_ERR) begin
      a_d = 1'b0;
      b_d = 1'b0;
    end

    // Clear wins over any error raised in the same cycle.
    if (bus.clr) begin
      err_tmo_d    = 1'b0;
      err_glitch_d = 1'b0;
      done_d       = '0;
      if (state_d == S_ERR) begin
        state_d = S_IDLE;
        a_d     = 1'b0;
        b_d     = 1'b0;
      end
    end
  end

  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;
  assign bus.busy       = (state_q != S_IDLE) && (state_q != S_ERR);
  assign bus.done_cnt   = done_q;
  assign bus.err_tmo    = err_tmo_q;
  assign bus.err_glitch = err_glitch_q;
endmodule

// File: tb/tb_muller_c_handshake_driver.sv
// Bench for the C-element handshake driver: a C-element model closes the
// loop, and a scoreboard checks handshake counts and lead/lag skews.
module tb_muller_c_handshake_driver;
  localparam int TMO_W = 8;
  localparam int CNT_W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  muller_c_handshake_driver_if #(.TMO_W(TMO_W), .CNT_W(CNT_W)) bus ();

  muller_c_handshake_driver #(
    .SYNC_STAGES (2),
    .TMO_W       (TMO_W),
    .CNT_W       (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // C-element model: 0 ideal, 1 output stuck low, 2 faulty (follows A|B).
  int   mode = 0;
  logic c_st = 1'b0;
  logic c_d1 = 1'b0;

  always @(negedge clk) begin
    bus.c_in = c_d1;
    case (mode)
      0: begin
        if (bus.a_out && bus.b_out)        c_st = 1'b1;
        else if (!bus.a_out && !bus.b_out) c_st = 1'b0;
      end
      1: c_st = 1'b0;
      default: c_st = bus.a_out | bus.b_out;
    endcase
    c_d1 = c_st;
  end

  // Scoreboard queues: expected done_cnt values and a-minus-b edge cycle offsets.
  int exp_cnt_q[$];
  int exp_rise_q[$];
  int exp_fall_q[$];
  int model_cnt = 0;
  int hs_seen   = 0;

  int   cyc = 0;
  int   a_r = 0, b_r = 0, a_f = 0, b_f = 0;
  logic a_p = 1'b0, b_p = 1'b0, risen = 1'b0;
  logic [CNT_W-1:0] done_p = '0;

  always @(negedge clk) begin
    cyc++;
    if (bus.a_out && !a_p) a_r = cyc;
    if (bus.b_out && !b_p) b_r = cyc;
    if (!bus.a_out && a_p) a_f = cyc;
    if (!bus.b_out && b_p) b_f = cyc;
    if (bus.a_out && bus.b_out && !(a_p && b_p)) begin
      risen = 1'b1;
      if (exp_rise_q.size() == 0) chk("rise_unexpected", 1, 0);
      else chk("rise_skew", a_r - b_r, exp_rise_q.pop_front());
    end
    if (!bus.a_out && !bus.b_out && (a_p || b_p) && risen) begin
      risen = 1'b0;
      if (exp_fall_q.size() == 0) chk("fall_unexpected", 1, 0);
      else chk("fall_skew", a_f - b_f, exp_fall_q.pop_front());
    end
    if (bus.done_cnt !== done_p) begin
      hs_seen++;
      if (exp_cnt_q.size() == 0) chk("cnt_unexpected", 32'(bus.done_cnt), -1);
      else chk("done_cnt", 32'(bus.done_cnt), exp_cnt_q.pop_front());
    end
    a_p    = bus.a_out;
    b_p    = bus.b_out;
    done_p = bus.done_cnt;
  end

  task automatic wait_busy(input logic val, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (bus.busy === val) break;
    end
    if (k == budget) chk("wait_busy_tmo", 0, 1);
  endtask

  task automatic wait_hs(input int target, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (hs_seen >= target) break;
      @(negedge clk); #1;
    end
    if (k == budget) chk("wait_hs_tmo", 0, 1);
  endtask

  // Run n handshakes with the given skew/lead and stop cleanly in IDLE.
  task automatic run_hs(input int n, input int sk, input logic lb);
    int base;
    for (int i = 0; i < n; i++) begin
      model_cnt = (model_cnt + 1) % (1 << CNT_W);
      exp_cnt_q.push_back(model_cnt);
      exp_rise_q.push_back(lb ? sk : -sk);
      exp_fall_q.push_back(lb ? sk : -sk);
    end
    base        = hs_seen;
    bus.skew    = 4'(sk);
    bus.lead_b  = lb;
    bus.tmo_lim = 8'd0;
    bus.stop    = 1'b0;
    bus.start   = 1'b1;
    wait_busy(1'b1, 10);
    wait_hs(base + n - 1, n * 50 + 50);
    bus.stop = 1'b1;
    wait_busy(1'b0, 100);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
  endtask

  task automatic do_clr();
    if (model_cnt != 0) exp_cnt_q.push_back(0);
    model_cnt = 0;
    @(negedge clk); #1;
    bus.clr = 1'b1;
    @(posedge clk); #1;
    bus.clr = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.clr = 1'b0; bus.lead_b = 1'b0;
    bus.skew = 4'd0; bus.tmo_lim = '0; bus.c_in = 1'b0;
    #1;
    chk("rst_a", 32'(bus.a_out), 0);
    chk("rst_b", 32'(bus.b_out), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done_cnt), 0);
    chk("rst_tmo", 32'(bus.err_tmo), 0);
    chk("rst_glitch", 32'(bus.err_glitch), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Ideal element, skew 0: three handshakes then stop.
    run_hs(3, 0, 1'b0);
    chk("t1_done", 32'(bus.done_cnt), 3);
    chk("t1_busy", 32'(bus.busy), 0);
    chk("t1_errs", 32'({bus.err_tmo, bus.err_glitch}), 0);

    // B leads by 5 cycles, then A leads by 3.
    run_hs(2, 5, 1'b1);
    run_hs(1, 3, 1'b0);
    chk("t2_done", 32'(bus.done_cnt), 6);

    // Faulty element reacts to the lead input alone.
    mode = 2;
    bus.skew = 4'd8; bus.lead_b = 1'b0; bus.tmo_lim = '0;
    @(negedge clk); #1;
    bus.start = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (bus.err_glitch === 1'b1) break;
    end
    chk("gl_flag", 32'(bus.err_glitch), 1);
    chk("gl_busy", 32'(bus.busy), 0);
    chk("gl_a", 32'(bus.a_out), 0);
    chk("gl_done", 32'(bus.done_cnt), 6);
    bus.start = 1'b0;
    mode = 0;
    repeat (4) @(negedge clk);
    do_clr();
    chk("gl_clr_flag", 32'(bus.err_glitch), 0);
    chk("gl_clr_done", 32'(bus.done_cnt), 0);

    // Element never answers: timeout exactly 20 cycles after W_HI entry.
    mode = 1;
    exp_rise_q.push_back(0);
    exp_fall_q.push_back(0);
    bus.skew = 4'd0; bus.tmo_lim = 8'd20;
    @(negedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("lead_lat_a", 32'(bus.a_out), 1);
    chk("lead_lat_b", 32'(bus.b_out), 1);
    repeat (20) @(posedge clk); #1;
    chk("tmo_early", 32'(bus.err_tmo), 0);
    @(posedge clk); #1;
    chk("tmo_flag", 32'(bus.err_tmo), 1);
    chk("tmo_outs", 32'({bus.a_out, bus.b_out}), 0);
    chk("tmo_busy", 32'(bus.busy), 0);
    bus.start = 1'b0;
    mode = 0;
    do_clr();
    chk("tmo_clr", 32'(bus.err_tmo), 0);
    chk("tmo_clr_busy", 32'(bus.busy), 0);

    // 17 handshakes on a 4-bit counter wrap to 1.
    run_hs(17, 0, 1'b0);
    chk("wrap_done", 32'(bus.done_cnt), 1);

    // Reset asserted while waiting in W_HI.
    mode = 1;
    exp_rise_q.push_back(0);
    exp_fall_q.push_back(0);
    bus.skew = 4'd0; bus.tmo_lim = '0;
    @(negedge clk); #1;
    bus.start = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    exp_cnt_q.push_back(0);
    model_cnt = 0;
    rst_n = 1'b0;
    #1;
    chk("arst_a", 32'(bus.a_out), 0);
    chk("arst_b", 32'(bus.b_out), 0);
    chk("arst_busy", 32'(bus.busy), 0);
    bus.start = 1'b0;
    mode = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("arst_done", 32'(bus.done_cnt), 0);
    chk("arst_errs", 32'({bus.err_tmo, bus.err_glitch}), 0);
    run_hs(1, 2, 1'b0);
    chk("post_rst_done", 32'(bus.done_cnt), 1);

    repeat (3) @(negedge clk);
    chk("sb_leftover", exp_cnt_q.size() + exp_rise_q.size() + exp_fall_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
